xbar_nxm: RTL and testbench

XBAR_NXM -- requirements
Module: xbar_nxm

---
 rtl/xbar_nxm.sv | 157 +++++++++++++++
 tb/tb_xbar_nxm.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbar_nxm.sv
// N-master by M-slave request crossbar with one round-robin arbiter and FSM
// per slave; outputs are routed combinationally from the registered owner.
module xbar_nxm #(
    parameter int N_M    = 4,
    parameter int N_S    = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_M-1:0]           m_req,
    input  logic [N_M*ADDR_W-1:0]    m_addr,
    input  logic [N_M-1:0]           m_cmd,
    input  logic [N_M*DATA_W-1:0]    m_wdata,
    output logic [N_M-1:0]           m_ack,
    output logic [N_M-1:0]           m_resp,
    output logic [N_M*DATA_W-1:0]    m_rdata,
    output logic [N_S-1:0]           s_req,
    output logic [N_S-1:0]           s_cmd,
    output logic [N_S*ADDR_W-1:0]    s_addr,
    output logic [N_S*DATA_W-1:0]    s_wdata,
    input  logic [N_S-1:0]           s_ack,
    input  logic [N_S-1:0]           s_resp,
    input  logic [N_S*DATA_W-1:0]    s_rdata
);

    localparam int SEL_W = $clog2(N_S);
    localparam int OWN_W = $clog2(N_M);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        WAIT_RESP
    } st_t;

    st_t              st_q  [N_S];
    logic [OWN_W-1:0] own_q [N_S];
    logic [OWN_W-1:0] rr_q  [N_S];
    logic [OWN_W-1:0] win   [N_S];
    logic [N_S-1:0]   hit;
    logic [N_M-1:0]   busy;
    logic [SEL_W-1:0] tgt   [N_M];

    function automatic logic [OWN_W-1:0] rr_next(input logic [OWN_W-1:0] o);
        return (o == OWN_W'(N_M - 1)) ? '0 : o + OWN_W'(1);
    endfunction

    always_comb begin
        for (int i = 0; i < N_M; i++) begin
            tgt[i] = m_addr[i*ADDR_W + ADDR_W - 1 -: SEL_W];
        end
    end

    // A master held by any non-idle slave (granted or awaiting read data)
    // may not be picked again, which also keeps ownership exclusive.
    always_comb begin
        busy = '0;
        for (int i = 0; i < N_M; i++) begin
            for (int s = 0; s < N_S; s++) begin
                if (st_q[s] != IDLE && own_q[s] == OWN_W'(i)) begin
                    busy[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        int   idx;
        logic found;
        for (int s = 0; s < N_S; s++) begin
            found  = 1'b0;
            win[s] = '0;
            for (int k = 0; k < N_M; k++) begin
                idx = int'(rr_q[s]) + k;
                if (idx >= N_M) begin
                    idx = idx - N_M;
                end
                if (!found && m_req[idx] && !busy[idx] &&
                    tgt[idx] == SEL_W'(s)) begin
                    found  = 1'b1;
                    win[s] = OWN_W'(idx);
                end
            end
            hit[s] = found;
        end
    end

    always_comb begin
        int o;
        s_req   = '0;
        s_cmd   = '0;
        s_addr  = '0;
        s_wdata = '0;
        m_ack   = '0;
        m_resp  = '0;
        m_rdata = '0;
        for (int s = 0; s < N_S; s++) begin
            o = int'(own_q[s]);
            if (st_q[s] == GRANT) begin
                s_req[s]                      = 1'b1;
                s_cmd[s]                      = m_cmd[o];
                s_addr[s*ADDR_W +: ADDR_W]    = m_addr[o*ADDR_W +: ADDR_W];
                s_wdata[s*DATA_W +: DATA_W]   = m_wdata[o*DATA_W +: DATA_W];
                if (s_ack[s]) begin
                    m_ack[o] = 1'b1;
                end
            end
            if (st_q[s] == WAIT_RESP && s_resp[s]) begin
                m_resp[o]                   = 1'b1;
                m_rdata[o*DATA_W +: DATA_W] = s_rdata[s*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < N_S; s++) begin
                st_q[s]  <= IDLE;
                own_q[s] <= '0;
                rr_q[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < N_S; s++) begin
                unique case (st_q[s])
                    IDLE: begin
                        if (hit[s]) begin
                            own_q[s] <= win[s];
                            st_q[s]  <= GRANT;
                        end
                    end
                    GRANT: begin
                        if (s_ack[s]) begin
                            rr_q[s] <= rr_next(own_q[s]);
                            st_q[s] <= m_cmd[own_q[s]] ? IDLE : WAIT_RESP;
                        end else if (!m_req[own_q[s]]) begin
                            st_q[s] <= IDLE;
                        end
                    end
                    WAIT_RESP: begin
                        if (s_resp[s]) begin
                            st_q[s] <= IDLE;
                        end
                    end
                    default: st_q[s] <= IDLE;
                endcase
            end
        end
    end

    // A read in flight blocks its master, so ack and resp never coincide.
    for (genvar i = 0; i < N_M; i++) begin : g_chk
        a_ack_resp : assert property (
            @(posedge clk) disable iff (!rst_n) !(m_ack[i] && m_resp[i])
        );
    end

endmodule

// File: tb/tb_xbar_nxm.sv
// Bench for xbar_nxm: directed cycle table, hand sequences, random vs model.
module tb_xbar_nxm;

    localparam int NM = 4;
    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [NM-1:0]    m_req, m_cmd, m_ack, m_resp;
    logic [NM*AW-1:0] m_addr;
    logic [NM*DW-1:0] m_wdata, m_rdata;
    logic [NS-1:0]    s_req, s_cmd, s_ack, s_resp;
    logic [NS*AW-1:0] s_addr;
    logic [NS*DW-1:0] s_wdata, s_rdata;

    xbar_nxm #(.N_M(NM), .N_S(NS), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_req(m_req), .m_addr(m_addr), .m_cmd(m_cmd), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_resp(m_resp), .m_rdata(m_rdata),
        .s_req(s_req), .s_cmd(s_cmd), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_resp(s_resp), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in;
        m_req = '0; m_cmd = '0; m_addr = '0; m_wdata = '0;
        s_ack = '0; s_resp = '0; s_rdata = '0;
    endtask

    task automatic mset(input int i, input bit rq, input bit cmd,
                        input logic [1:0] tg, input logic [31:0] lo,
                        input logic [31:0] wd);
        m_req[i] = rq;
        m_cmd[i] = cmd;
        m_addr[i*AW +: AW] = {tg, lo[29:0]};
        m_wdata[i*DW +: DW] = wd;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ctl"}, {m_ack, m_resp, s_req, s_cmd}, '0);
        chk({nm, "_rdata"}, m_rdata, '0);
        chk({nm, "_saddr"}, s_addr, '0);
        chk({nm, "_swdata"}, s_wdata, '0);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        clr_in();
        #1;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Reference model: per slave, which master holds it (-1 = free),
    // whether that holder is waiting for read data, and its priority start.
    int hold [NS];
    bit wt   [NS];
    int pri  [NS];

    task automatic mdl_reset;
        for (int s = 0; s < NS; s++) begin
            hold[s] = -1; wt[s] = 1'b0; pri[s] = 0;
        end
    endtask

    task automatic mdl_out(output logic [NM-1:0] e_mack,
                           output logic [NM-1:0] e_mresp,
                           output logic [NS-1:0] e_sreq,
                           output logic [NS-1:0] e_scmd,
                           output logic [NM*DW-1:0] e_rdata,
                           output logic [NS*AW-1:0] e_saddr,
                           output logic [NS*DW-1:0] e_swdata);
        e_mack = '0; e_mresp = '0; e_sreq = '0; e_scmd = '0;
        e_rdata = '0; e_saddr = '0; e_swdata = '0;
        for (int s = 0; s < NS; s++) begin
            int h;
            h = hold[s];
            if (h >= 0 && !wt[s]) begin
                e_sreq[s] = 1'b1;
                e_scmd[s] = m_cmd[h];
                e_saddr[s*AW +: AW] = m_addr[h*AW +: AW];
                e_swdata[s*DW +: DW] = m_wdata[h*DW +: DW];
                if (s_ack[s]) e_mack[h] = 1'b1;
            end
            if (h >= 0 && wt[s] && s_resp[s]) begin
                e_mresp[h] = 1'b1;
                e_rdata[h*DW +: DW] = s_rdata[s*DW +: DW];
            end
        end
    endtask

    task automatic mdl_step;
        int nh [NS];
        bit nw [NS];
        bit bsy [NM];
        for (int i = 0; i < NM; i++) begin
            bsy[i] = 1'b0;
            for (int s = 0; s < NS; s++) if (hold[s] == i) bsy[i] = 1'b1;
        end
        for (int s = 0; s < NS; s++) begin
            nh[s] = hold[s];
            nw[s] = wt[s];
            if (hold[s] < 0) begin
                bit found;
                found = 1'b0;
                for (int k = 0; k < NM; k++) begin
                    int i;
                    i = (pri[s] + k) % NM;
                    if (!found && m_req[i] && !bsy[i] &&
                        int'(m_addr[i*AW + 30 +: 2]) == s) begin
                        found = 1'b1;
                        nh[s] = i;
                    end
                end
            end else if (!wt[s]) begin
                if (s_ack[s]) begin
                    pri[s] = (hold[s] + 1) % NM;
                    if (m_cmd[hold[s]]) nh[s] = -1;
                    else nw[s] = 1'b1;
                end else if (!m_req[hold[s]]) begin
                    nh[s] = -1;
                end
            end else if (s_resp[s]) begin
                nh[s] = -1;
                nw[s] = 1'b0;
            end
        end
        for (int s = 0; s < NS; s++) begin
            hold[s] = nh[s];
            wt[s] = nw[s];
        end
    endtask

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] cmd;
        logic [7:0] tgt;
        logic [3:0] ack;
        logic [3:0] resp;
        logic [3:0] e_sreq;
        logic [3:0] e_mack;
        logic [3:0] e_mresp;
    } vec_t;

    vec_t tbl [17];

    initial begin
        logic [NM-1:0]    e_mack, e_mresp;
        logic [NS-1:0]    e_sreq, e_scmd;
        logic [NM*DW-1:0] e_rdata;
        logic [NS*AW-1:0] e_saddr;
        logic [NS*DW-1:0] e_swdata;
        int exp_order [5];
        int got;

        // req cmd tgt ack resp | s_req m_ack m_resp
        tbl[0]  = '{4'b0001, 4'b0001, 8'h01, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0001, 4'b0001, 8'h01, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
        tbl[2]  = '{4'b0001, 4'b0001, 8'h01, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
        tbl[3]  = '{4'b0001, 4'b0001, 8'h01, 4'b0010, 4'b0000, 4'b0010, 4'b0001, 4'b0000};
        tbl[4]  = '{4'b0000, 4'b0001, 8'h01, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[5]  = '{4'b0011, 4'b0011, 8'h0C, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[6]  = '{4'b0011, 4'b0011, 8'h0C, 4'b0000, 4'b0000, 4'b1001, 4'b0000, 4'b0000};
        tbl[7]  = '{4'b0011, 4'b0011, 8'h0C, 4'b1000, 4'b0000, 4'b1001, 4'b0010, 4'b0000};
        tbl[8]  = '{4'b0001, 4'b0011, 8'h0C, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
        tbl[9]  = '{4'b0000, 4'b0011, 8'h0C, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[10] = '{4'b0100, 4'b0100, 8'h20, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[11] = '{4'b0000, 4'b0100, 8'h20, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
        tbl[12] = '{4'b0000, 4'b0100, 8'h20, 4'b0100, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
        tbl[13] = '{4'b1000, 4'b0000, 8'hC0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[14] = '{4'b1000, 4'b0000, 8'hC0, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b0000};
        tbl[15] = '{4'b0000, 4'b0000, 8'hC0, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b1000};
        tbl[16] = '{4'b0000, 4'b0000, 8'hC0, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};

        #2;
        do_reset();
        for (int k = 0; k < 17; k++) begin
            for (int i = 0; i < NM; i++) begin
                mset(i, tbl[k].req[i], tbl[k].cmd[i], tbl[k].tgt[2*i +: 2],
                     32'h0000_0010 + i, 32'hA5A5_A5A5 ^ i);
            end
            s_ack = tbl[k].ack;
            s_resp = tbl[k].resp;
            #4;
            chk($sformatf("tbl%0d_sreq", k), s_req, tbl[k].e_sreq);
            chk($sformatf("tbl%0d_mack", k), m_ack, tbl[k].e_mack);
            chk($sformatf("tbl%0d_mresp", k), m_resp, tbl[k].e_mresp);
            if (k == 3) begin
                chk("tbl3_s1_addr", s_addr[63:32], 32'h4000_0010);
                chk("tbl3_s1_wdata", s_wdata[63:32], 32'hA5A5_A5A5);
            end
            nxt();
        end

        // All masters read slave 2 back to back; grants must rotate.
        do_reset();
        exp_order = '{0, 1, 2, 3, 0};
        got = 0;
        for (int i = 0; i < NM; i++) mset(i, 1'b1, 1'b0, 2'd2, 32'h40 + i, 0);
        s_ack = 4'b0100;
        s_resp = 4'b0100;
        s_rdata[95:64] = 32'h1234_5678;
        for (int c = 0; c < 60 && got < 5; c++) begin
            #4;
            if (m_ack != 0) begin
                chk($sformatf("rr_grant%0d", got), m_ack, 1 << exp_order[got]);
                got++;
            end
            nxt();
        end
        chk("rr_count", got, 5);

        // Read with delayed response; the reader is blocked meanwhile.
        do_reset();
        mset(2, 1'b1, 1'b0, 2'd1, 32'h20, 0);
        s_rdata[63:32] = 32'hDEAD_BEEF;
        #4;
        chk("rd_c0_sreq", s_req, 4'b0000);
        nxt();
        s_ack[1] = 1'b1;
        #4;
        chk("rd_ack", {s_req, m_ack}, {4'b0010, 4'b0100});
        nxt();
        s_ack = '0;
        mset(2, 1'b1, 1'b0, 2'd0, 32'h24, 0);
        for (int c = 0; c < 4; c++) begin
            #4;
            chk($sformatf("rd_block%0d", c), {s_req, m_resp, m_ack}, '0);
            nxt();
        end
        s_resp[1] = 1'b1;
        #4;
        chk("rd_resp", m_resp, 4'b0100);
        chk("rd_rdata", m_rdata, 128'hDEAD_BEEF << 64);
        nxt();
        s_resp = '0;
        #4;
        chk("rd_after_sreq", {s_req, m_resp}, '0);
        nxt();
        #4;
        chk("rd_regrant_sreq", s_req, 4'b0001);
        m_req = '0;
        nxt();

        // Reset while a read is outstanding.
        do_reset();
        mset(1, 1'b1, 1'b0, 2'd3, 32'h80, 0);
        nxt();
        s_ack[3] = 1'b1;
        #1;
        chk("rst_seq_ack", m_ack, 4'b0010);
        nxt();
        s_ack = '0;
        m_req = '0;
        #2;
        rst_n = 1'b0;
        s_resp[3] = 1'b1;
        s_rdata[127:96] = 32'hCAFE_F00D;
        #1;
        chk_zero("rst_mid");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #4;
        chk("rst_late_resp", {m_resp, m_rdata}, '0);
        nxt();
        s_resp = '0;
        mset(0, 1'b1, 1'b1, 2'd3, 32'h100, 32'h1111_0000);
        mset(3, 1'b1, 1'b1, 2'd3, 32'h300, 32'h3333_0000);
        nxt();
        #1;
        chk("rst_rr_addr", s_addr[127:96], 32'hC000_0100);
        s_ack[3] = 1'b1;
        #1;
        chk("rst_rr_ack", m_ack, 4'b0001);
        nxt();
        clr_in();

        // Random traffic against the model.
        do_reset();
        mdl_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NM; i++) begin
                if ($urandom_range(9) < 3) begin
                    mset(i, ($urandom % 4) != 0, $urandom % 2,
                         2'($urandom % 4), $urandom, $urandom);
                end
            end
            s_ack = 4'($urandom);
            s_resp = 4'($urandom);
            for (int s = 0; s < NS; s++) s_rdata[s*DW +: DW] = $urandom;
            #4;
            mdl_out(e_mack, e_mresp, e_sreq, e_scmd, e_rdata, e_saddr, e_swdata);
            chk($sformatf("rnd%0d_ctl", c), {m_ack, m_resp, s_req, s_cmd},
                {e_mack, e_mresp, e_sreq, e_scmd});
            chk($sformatf("rnd%0d_rdata", c), m_rdata, e_rdata);
            chk($sformatf("rnd%0d_saddr", c), s_addr, e_saddr);
            chk($sformatf("rnd%0d_swdata", c), s_wdata, e_swdata);
            mdl_step();
            nxt();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
